breath_ramp: RTL

Triangle-envelope duty generator that drives the PWM stage's `dutyRatio` input to produce a "breathing" LED. It consumes the PWM stage's end-of-period strobe and updates duty only on PWM period boundaries, so no PWM period is ever glitched. It cycles through ramp-up, hold-high, ramp-down and hold-low. It sits directly upstream of the PWM stage and shares its `DEGREE`.

---
 rtl/breath_pkg.sv | 42 ++++
 rtl/step_tick_counter.sv | 31 +++
 rtl/breath_ramp.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/breath_pkg.sv
// Shared phase encoding, duty width and saturating duty helpers for the breathing-LED ramp.
// Latency: none (package).
// Backpressure: none (package).
package breath_pkg;

  localparam int DUTY_W = 10;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HIGH = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LOW  = 2'd3
  } phase_t;

  // Add one step with one bit of headroom, then clamp at full scale.
  function automatic logic [DUTY_W-1:0] duty_up(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W:0]   step,
    input logic [DUTY_W:0]   full
  );
    logic [DUTY_W:0] sum;
    sum = {1'b0, duty} + step;
    if (sum >= full) begin
      return full[DUTY_W-1:0];
    end
    return sum[DUTY_W-1:0];
  endfunction

  // Subtract one step with one bit of headroom; a set top bit means it went below zero.
  function automatic logic [DUTY_W-1:0] duty_down(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W:0]   step
  );
    logic [DUTY_W:0] diff;
    diff = {1'b0, duty} - step;
    if (diff[DUTY_W]) begin
      return '0;
    end
    return diff[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/step_tick_counter.sv
// Modulo counter of enabled ticks; tc flags the tick on which the count equals 'last'.
// Latency: tc is combinational from en and the registered count; count updates next edge.
// Backpressure: none; count holds whenever en is low.
module step_tick_counter #(
  parameter  int MAX = 4,
  localparam int CW  = $clog2(MAX) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] last,
  output logic          tc
);

  logic [CW-1:0] count;

  assign tc = en & (count == last);

  // Count enabled ticks, wrapping to zero on the terminal tick; clear wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/breath_ramp.sv
// Triangle duty envelope for a PWM stage: ramp up, hold high, ramp down, hold low, repeat.
// Latency: duty/phase update on the same edge that samples periodTail with enable high.
// Backpressure: none; enable low freezes all state, ticks with enable low are dropped.
module breath_ramp
  import breath_pkg::*;
#(
  parameter int DEGREE            = 100,
  parameter int STEP_SIZE         = 1,
  parameter int STEP_PERIODS      = 4,
  parameter int HOLD_HIGH_PERIODS = 50,
  parameter int HOLD_LOW_PERIODS  = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              periodTail,
  output logic [DUTY_W-1:0] dutyRatio,
  output logic [1:0]        phase,
  output logic              cycleDone
);

  localparam int DW1 = DUTY_W + 1;
  localparam logic [DUTY_W:0] FULL = DW1'(DEGREE);
  localparam logic [DUTY_W:0] STEP = DW1'(STEP_SIZE);

  // Step counter sizing.
  localparam int SCW = $clog2(STEP_PERIODS) + 1;

  // One hold counter serves both holds, so size it for the longer one; a zero
  // hold never enables it, so its terminal value is irrelevant in that case.
  localparam int HOLD_BIG = (HOLD_HIGH_PERIODS > HOLD_LOW_PERIODS) ? HOLD_HIGH_PERIODS
                                                                   : HOLD_LOW_PERIODS;
  localparam int HOLD_MAX = (HOLD_BIG > 0) ? HOLD_BIG : 1;
  localparam int HCW      = $clog2(HOLD_MAX) + 1;
  localparam int HH_LAST  = (HOLD_HIGH_PERIODS > 0) ? HOLD_HIGH_PERIODS - 1 : 0;
  localparam int HL_LAST  = (HOLD_LOW_PERIODS > 0) ? HOLD_LOW_PERIODS - 1 : 0;

  phase_t            phase_q,  phase_nxt;
  logic [DUTY_W-1:0] duty_q,   duty_nxt;
  logic              done_q,   done_nxt;

  logic              tick;
  logic              in_ramp, in_hold;
  logic              step_tc, hold_tc;
  logic              leave_phase;
  logic [HCW-1:0]    hold_last;
  logic [DUTY_W-1:0] duty_inc, duty_dec;

  assign tick        = periodTail & enable;
  assign in_ramp     = (phase_q == RAMP_UP) || (phase_q == RAMP_DOWN);
  assign in_hold     = (phase_q == HOLD_HIGH) || (phase_q == HOLD_LOW);
  assign hold_last   = (phase_q == HOLD_HIGH) ? HCW'(HH_LAST) : HCW'(HL_LAST);
  assign leave_phase = tick & (phase_nxt != phase_q);
  assign duty_inc    = duty_up(duty_q, STEP, FULL);
  assign duty_dec    = duty_down(duty_q, STEP);

  step_tick_counter #(
    .MAX (STEP_PERIODS)
  ) u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick & in_ramp),
    .clr   (leave_phase),
    .last  (SCW'(STEP_PERIODS - 1)),
    .tc    (step_tc)
  );

  step_tick_counter #(
    .MAX (HOLD_MAX)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick & in_hold),
    .clr   (leave_phase),
    .last  (hold_last),
    .tc    (hold_tc)
  );

  // Phase sequencing and saturating duty steps; everything holds unless a tick arrives.
  always_comb begin
    phase_nxt = phase_q;
    duty_nxt  = duty_q;
    done_nxt  = 1'b0;
    if (tick) begin
      case (phase_q)
        RAMP_UP: begin
          if (step_tc) begin
            duty_nxt = duty_inc;
            if ({1'b0, duty_inc} == FULL) begin
              phase_nxt = (HOLD_HIGH_PERIODS == 0) ? RAMP_DOWN : HOLD_HIGH;
            end
          end
        end
        HOLD_HIGH: begin
          if (hold_tc) begin
            phase_nxt = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (step_tc) begin
            duty_nxt = duty_dec;
            if (duty_dec == '0) begin
              if (HOLD_LOW_PERIODS == 0) begin
                phase_nxt = RAMP_UP;
                done_nxt  = 1'b1;
              end else begin
                phase_nxt = HOLD_LOW;
              end
            end
          end
        end
        HOLD_LOW: begin
          if (hold_tc) begin
            phase_nxt = RAMP_UP;
            done_nxt  = 1'b1;
          end
        end
        default: phase_nxt = RAMP_UP;
      endcase
    end
  end

  // State, duty and the one-clock breath-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= RAMP_UP;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_nxt;
      duty_q  <= duty_nxt;
      done_q  <= done_nxt;
    end
  end

  assign dutyRatio = duty_q;
  assign phase     = phase_q;
  assign cycleDone = done_q;

endmodule
